// File: rtl/icache_pkg.sv
// icache_pkg: FSM state encoding, no-request sentinel and width helpers shared by the cache files
package icache_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    READ_MEM = 2'b01,
    UPDATE   = 2'b10
  } state_e;
  localparam logic [63:0] NO_REQ_ADDR = 64'hFFFF_FFFF_FFFF_FFFC;
  function automatic int off_w(int words);
    return $clog2(words * 4);
  endfunction
  function automatic int idx_w(int sets);
    return $clog2(sets);
  endfunction
  function automatic int tag_w(int aw, int sets, int words);
    return aw - off_w(words) - idx_w(sets);
  endfunction
  function automatic int way_w(int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction
endpackage

// File: rtl/icache_way.sv
// icache_way: one way of the cache; per-set block, tag and valid with combinational lookup
module icache_way #(
  parameter int NUM_SETS = 8,
  parameter int IDX_W    = 3,
  parameter int TAG_W    = 25,
  parameter int BLK_W    = 128
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [TAG_W-1:0] rd_tag_i,
  output logic             hit_o,
  output logic [BLK_W-1:0] rd_blk_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [BLK_W-1:0] wr_blk_i,
  output logic             wr_vld_o
);
  logic [BLK_W-1:0]    data_q [NUM_SETS];
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) valid_q <= '0;
    else if (clr_i) valid_q <= '0;
    else if (wr_en_i) valid_q[wr_idx_i] <= 1'b1;

  // payload needs no reset: a line is only visible through its valid bit
  always_ff @(posedge clk_i)
    if (wr_en_i) begin
      data_q[wr_idx_i] <= wr_blk_i;
      tag_q[wr_idx_i]  <= wr_tag_i;
    end

  assign hit_o    = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_blk_o = data_q[rd_idx_i];
  assign wr_vld_o = valid_q[wr_idx_i];
endmodule

// File: rtl/set_assoc_instruction_cache.sv
// set_assoc_instruction_cache: N-way read-only I-cache with round-robin refill,
// flush and saturating hit/miss counters
module set_assoc_instruction_cache
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int NUM_SETS        = 8,
  parameter int NUM_WAYS        = 2,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [ADDR_WIDTH-1:0]                        address,
  input  logic                                         flush,
  output logic [31:0]                                  readinst,
  output logic                                         busywait,
  output logic [ADDR_WIDTH-off_w(WORDS_PER_BLOCK)-1:0] mem_address,
  output logic                                         mem_read,
  input  logic [32*WORDS_PER_BLOCK-1:0]                mem_readinst,
  input  logic                                         mem_busywait,
  output logic [CNT_WIDTH-1:0]                         hit_count,
  output logic [CNT_WIDTH-1:0]                         miss_count
);
  localparam int OFF_W = off_w(WORDS_PER_BLOCK);
  localparam int IDX_W = idx_w(NUM_SETS);
  localparam int TAG_W = tag_w(ADDR_WIDTH, NUM_SETS, WORDS_PER_BLOCK);
  localparam int WAY_W = way_w(NUM_WAYS);
  localparam int BLK_W = 32 * WORDS_PER_BLOCK;
  localparam int BA_W  = ADDR_WIDTH - OFF_W;
  localparam logic [ADDR_WIDTH-1:0] NO_REQ = NO_REQ_ADDR[ADDR_WIDTH-1:0];

  state_e                         state_q, state_d;
  logic [BA_W-1:0]                miss_blk_q, miss_blk_d;
  logic                           flush_pend_q, flush_pend_d;
  logic [NUM_SETS-1:0][WAY_W-1:0] ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]           hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [NUM_WAYS-1:0]            way_hit, way_vld;
  logic [BLK_W-1:0]               way_blk [NUM_WAYS];
  logic [WORDS_PER_BLOCK-1:0][31:0] hit_blk;
  logic [WAY_W-1:0]               victim;
  logic                           req, idle, hit, miss, fill, clr;

  assign req  = address != NO_REQ;
  assign idle = state_q == IDLE;
  // a flush in IDLE wipes the lines on this edge, so nothing may hit or miss with it
  assign hit  = req && (|way_hit) && !(idle && flush);
  assign miss = idle && req && !hit && !flush;
  assign fill = (state_q == READ_MEM) && !mem_busywait;
  assign clr  = (idle && flush) || ((state_q == UPDATE) && (flush_pend_q || flush));

  assign busywait    = (req && !hit) || !idle;
  assign mem_read    = state_q == READ_MEM;
  assign mem_address = miss_blk_q;
  assign readinst    = hit_blk[address[2 +: OFF_W-2]];
  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    icache_way #(
      .NUM_SETS(NUM_SETS),
      .IDX_W   (IDX_W),
      .TAG_W   (TAG_W),
      .BLK_W   (BLK_W)
    ) u_way (
      .clk_i   (clock),
      .rst_i   (reset),
      .clr_i   (clr),
      .rd_idx_i(address[OFF_W +: IDX_W]),
      .rd_tag_i(address[ADDR_WIDTH-1 -: TAG_W]),
      .hit_o   (way_hit[w]),
      .rd_blk_o(way_blk[w]),
      .wr_en_i (fill && (victim == WAY_W'(w))),
      .wr_idx_i(miss_blk_q[IDX_W-1:0]),
      .wr_tag_i(miss_blk_q[BA_W-1 -: TAG_W]),
      .wr_blk_i(mem_readinst),
      .wr_vld_o(way_vld[w])
    );
  end

  always_comb begin
    hit_blk = '0;
    for (int i = 0; i < NUM_WAYS; i++) hit_blk |= way_hit[i] ? way_blk[i] : '0;
  end

  // lowest-numbered invalid way wins; otherwise the set's round-robin pointer
  always_comb begin
    victim = ptr_q[miss_blk_q[IDX_W-1:0]];
    for (int i = NUM_WAYS - 1; i >= 0; i--) victim = way_vld[i] ? victim : WAY_W'(i);
  end

  always_comb begin
    state_d      = miss ? READ_MEM : fill ? UPDATE : (state_q == UPDATE) ? IDLE : state_q;
    miss_blk_d   = miss ? address[ADDR_WIDTH-1:OFF_W] : miss_blk_q;
    flush_pend_d = (state_q == UPDATE) ? 1'b0 : flush_pend_q || (flush && !idle);
    ptr_d        = ptr_q;
    if (fill && (&way_vld))
      ptr_d[miss_blk_q[IDX_W-1:0]] = (victim == WAY_W'(NUM_WAYS - 1)) ? '0 : victim + 1'b1;
    hit_cnt_d    = (idle && hit && !(&hit_cnt_q)) ? hit_cnt_q + 1'b1 : hit_cnt_q;
    miss_cnt_d   = (miss && !(&miss_cnt_q)) ? miss_cnt_q + 1'b1 : miss_cnt_q;
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      miss_blk_q   <= '0;
      flush_pend_q <= 1'b0;
      ptr_q        <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      miss_blk_q   <= miss_blk_d;
      flush_pend_q <= flush_pend_d;
      ptr_q        <= ptr_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
endmodule

// File: tb/tb_set_assoc_instruction_cache.sv
// tb_set_assoc_instruction_cache: directed and random fetches scored against a set/way
// reference model, with a latency-programmable block memory
module tb_set_assoc_instruction_cache;
  localparam int NS  = 8;
  localparam int NW  = 2;
  localparam int WPB = 4;
  localparam logic [31:0] NO_REQ = 32'hFFFF_FFFC;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          hit;
  } exp_t;

  logic         clock = 1'b0, reset = 1'b1, flush = 1'b0;
  logic [31:0]  address = NO_REQ;
  logic [31:0]  readinst, hit_count, miss_count;
  logic         busywait, mem_read, mem_busywait = 1'b1;
  logic [27:0]  mem_address, first_maddr;
  logic [127:0] mem_readinst = '0;

  int tests = 0, fails = 0;
  int lat = 5, mcnt = 0, mr_total = 0, unstable = 0;
  int stall_cyc = 0, exp_hits = 0, exp_miss = 0;
  bit rand_lat = 0, stalled = 0;
  exp_t q[$];
  exp_t mon_e;

  logic [24:0] m_tag [NS][NW];
  bit          m_vld [NS][NW];
  int          m_ptr [NS];

  set_assoc_instruction_cache dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .flush       (flush),
    .readinst    (readinst),
    .busywait    (busywait),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .mem_readinst(mem_readinst),
    .mem_busywait(mem_busywait),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word_val(input logic [31:0] a);
    return (a >> 2) * 32'h9E37_79B1 ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void m_clear(input bit rst_ptr);
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < NW; w++) m_vld[s][w] = 0;
      if (rst_ptr) m_ptr[s] = 0;
    end
  endfunction

  // returns 1 on hit; on a miss installs the block as the cache rules dictate
  function automatic bit m_access(input logic [31:0] a);
    int s = int'(a[6:4]);
    int v = -1;
    for (int w = 0; w < NW; w++)
      if (m_vld[s][w] && m_tag[s][w] == a[31:7]) return 1'b1;
    for (int w = NW - 1; w >= 0; w--)
      if (!m_vld[s][w]) v = w;
    if (v < 0) begin
      v = m_ptr[s];
      m_ptr[s] = (m_ptr[s] + 1) % NW;
    end
    m_vld[s][v] = 1;
    m_tag[s][v] = a[31:7];
    return 1'b0;
  endfunction

  always @(negedge clock) begin
    if (mem_read) begin
      if (mcnt == 0) begin
        first_maddr = mem_address;
        if (rand_lat) lat = $urandom_range(1, 6);
      end else if (mem_address !== first_maddr) unstable++;
      mcnt++;
      mr_total++;
      mem_busywait = mcnt < lat;
    end else begin
      mcnt = 0;
      mem_busywait = 1'b1;
    end
    for (int k = 0; k < WPB; k++) mem_readinst[32*k +: 32] = word_val({mem_address, 4'(4 * k)});
  end

  always @(negedge clock)
    if (!reset && address !== NO_REQ && q.size() > 0) begin
      if (busywait) begin
        stalled = 1;
        stall_cyc++;
      end else begin
        mon_e = q.pop_front();
        chk("readinst", readinst, mon_e.data);
        chk("hit_vs_model", !stalled, mon_e.hit);
        if (!mon_e.hit) chk("miss_penalty", stall_cyc, lat + 2);
        stalled = 0;
        stall_cyc = 0;
      end
    end

  task automatic do_reset();
    reset = 1;
    flush = 0;
    address = NO_REQ;
    q.delete();
    stalled = 0;
    stall_cyc = 0;
    m_clear(1);
    exp_hits = 0;
    exp_miss = 0;
    @(posedge clock);
    #1 reset = 0;
    mr_total = 0;
  endtask

  task automatic fetch(input logic [31:0] a);
    exp_t e;
    int n = 0;
    e.addr = a;
    e.data = word_val(a);
    e.hit  = m_access(a);
    exp_hits++;
    if (!e.hit) exp_miss++;
    q.push_back(e);
    address = a;
    while (q.size() != 0 && n < 60) begin
      @(posedge clock);
      n++;
    end
    chk("fetch_done", q.size(), 0);
    q.delete();
    #1;
  endtask

  task automatic wait_mem_read();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!mem_read && n < 20);
    chk("mem_read_seen", mem_read, 1);
  endtask

  task automatic chk_counts(input string name);
    chk({name, "_hits"}, hit_count, exp_hits);
    chk({name, "_misses"}, miss_count, exp_miss);
  endtask

  initial begin
    int n;
    #2;
    chk("rst_busywait", busywait, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    do_reset();

    fetch(32'h100);
    chk("t1_mem_cycles", mr_total, 5);
    chk("t1_mem_addr", first_maddr, 28'h10);
    chk("t1_addr_stable", unstable, 0);
    chk("t1_miss", miss_count, 1);

    fetch(32'h104);
    fetch(32'h108);
    fetch(32'h10C);
    chk_counts("t2");

    do_reset();
    fetch(32'h000);
    fetch(32'h080);
    fetch(32'h100);
    fetch(32'h080);
    fetch(32'h000);
    chk_counts("t3");

    do_reset();
    address = 32'h100;
    wait_mem_read();
    @(posedge clock);
    #1 flush = 1;
    address = NO_REQ;
    @(posedge clock);
    #1 flush = 0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (busywait && n < 30);
    chk("t4_release", busywait, 0);
    chk("t4_mem_cycles", mr_total, 5);
    chk("t4_misses", miss_count, 1);
    @(posedge clock);
    #1 exp_miss = 1;
    fetch(32'h100);
    chk_counts("t4");

    do_reset();
    address = 32'h100;
    wait_mem_read();
    #2 reset = 1;
    address = NO_REQ;
    #1;
    chk("t5_mem_read", mem_read, 0);
    chk("t5_busywait", busywait, 0);
    chk("t5_hits", hit_count, 0);
    chk("t5_misses", miss_count, 0);
    do_reset();
    fetch(32'h100);
    chk_counts("t5");

    address = NO_REQ;
    repeat (10) begin
      @(negedge clock);
      chk("t6_busywait", busywait, 0);
      chk("t6_mem_read", mem_read, 0);
    end
    chk_counts("t6");
    @(posedge clock);
    #1;

    do_reset();
    rand_lat = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        address = NO_REQ;
        flush = 1;
        @(posedge clock);
        #1 flush = 0;
        m_clear(0);
      end else fetch(32'($urandom_range(0, 255)) << 2);
    end
    chk_counts("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
